// File: rtl/pio_cmd_sequencer.sv
// pio_cmd_sequencer: decodes toggle-handshaked 32-bit PIO command words,
// holds a 24-bit configuration register file and runs a burst trigger engine
// (COUNT pulses spaced reg0 clocks apart).
// Optional build macro: PIO_SEQ_ERR_EN adds err_count / err_flag outputs that
// track illegal opcodes and out-of-range register writes.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | waiting for pio_data[31] to differ from ack_toggle
// ST_QUAL | word latched, waiting for it to hold STABLE_CYCLES samples
// ST_EXEC | one cycle: execute latched opcode, flip ack, bump cmd_count
module pio_cmd_sequencer #(
    parameter int NUM_REGS      = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [31:0]            pio_data,
    output logic [NUM_REGS*24-1:0] cfg_regs,
    output logic                   trig_out,
    output logic                   busy,
    output logic                   ack_toggle,
    output logic [15:0]            cmd_count
`ifdef PIO_SEQ_ERR_EN
    ,
    output logic [7:0]             err_count,
    output logic [0:0]             err_flag
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_QUAL, ST_EXEC} state_t;

    localparam int              SCW       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SCW-1:0]  STAB_LOAD = SCW'(STABLE_CYCLES - 1);
    localparam logic [4:0]      NREG      = 5'(NUM_REGS);

    state_t         state_q, state_d;
    logic [31:0]    word_q, word_d;
    logic [SCW-1:0] stab_q, stab_d;
    logic           ack_q, ack_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [23:0]    regs_q [NUM_REGS];
    logic [23:0]    regs_d [NUM_REGS];
    logic           trig_q, trig_d;
    logic           busy_q, busy_d;
    logic [23:0]    rem_q, rem_d;
    logic [23:0]    per_q, per_d;

    logic [2:0]     op;
    logic [3:0]     addr;
    logic [23:0]    data;
    logic [23:0]    p_val;

    assign op    = word_q[30:28];
    assign addr  = word_q[27:24];
    assign data  = word_q[23:0];
    // A zero period would stall the engine, so it runs at one pulse per clock.
    assign p_val = (regs_q[0] == 24'd0) ? 24'd1 : regs_q[0];

    // State, handshake, register file and burst engine registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            stab_q  <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
            per_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            stab_q  <= stab_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Next-state: burst engine first, then decoder commands override it.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        stab_d  = stab_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        busy_d  = busy_q;
        rem_d   = rem_q;
        per_d   = per_q;
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

        if (busy_q) begin
            if (per_q <= 24'd1) begin
                trig_d = 1'b1;
                rem_d  = rem_q - 24'd1;
                busy_d = (rem_q > 24'd1);
                per_d  = p_val;
            end else begin
                per_d  = per_q - 24'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pio_data[31] != ack_q) begin
                    word_d  = pio_data;
                    stab_d  = STAB_LOAD;
                    state_d = (STABLE_CYCLES == 1) ? ST_EXEC : ST_QUAL;
                end
            end
            ST_QUAL: begin
                if (pio_data[31] == ack_q) begin
                    state_d = ST_IDLE;
                end else if (pio_data != word_q) begin
                    word_d = pio_data;
                    stab_d = STAB_LOAD;
                end else if (stab_q <= SCW'(1)) begin
                    state_d = ST_EXEC;
                end else begin
                    stab_d = stab_q - SCW'(1);
                end
            end
            ST_EXEC: begin
                ack_d   = word_q[31];
                cnt_d   = cnt_q + 16'd1;
                state_d = ST_IDLE;
                case (op)
                    3'd1: begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if ({1'b0, addr} == 5'(i)) regs_d[i] = data;
                    end
                    3'd2: begin
                        if (data == 24'd0) begin
                            trig_d = 1'b0;
                            busy_d = 1'b0;
                        end else begin
                            trig_d = 1'b1;
                            rem_d  = data - 24'd1;
                            busy_d = (data > 24'd1);
                            per_d  = p_val;
                        end
                    end
                    3'd3: begin
                        trig_d = 1'b0;
                        busy_d = 1'b0;
                    end
                    3'd4: begin
                        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flatten the register file onto the output bus.
    always_comb begin
        cfg_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) cfg_regs[i*24 +: 24] = regs_q[i];
    end

    assign trig_out   = trig_q;
    assign busy       = busy_q;
    assign ack_toggle = ack_q;
    assign cmd_count  = cnt_q;

`ifdef PIO_SEQ_ERR_EN
    logic [7:0] errc_q, errc_d;
    logic       errf_q, errf_d;
    logic       err_hit, err_clr;

    // Error bookkeeping: saturating count, sticky flag cleared by CLEAR.
    always_comb begin
        err_hit = (state_q == ST_EXEC) &&
                  ((op >= 3'd5) || ((op == 3'd1) && ({1'b0, addr} >= NREG)));
        err_clr = (state_q == ST_EXEC) && (op == 3'd4);
        errc_d  = errc_q;
        errf_d  = errf_q;
        if (err_hit && (errc_q != 8'hFF)) errc_d = errc_q + 8'd1;
        if (err_hit)      errf_d = 1'b1;
        else if (err_clr) errf_d = 1'b0;
    end

    // Error registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            errc_q <= '0;
            errf_q <= 1'b0;
        end else begin
            errc_q <= errc_d;
            errf_q <= errf_d;
        end
    end

    assign err_count = errc_q;
    assign err_flag  = errf_q;
`endif

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Directed bench for pio_cmd_sequencer (NUM_REGS=4, STABLE_CYCLES=2).
module tb_pio_cmd_sequencer;

    logic        clk_clk;
    logic        reset_reset;
    logic [31:0] pio_data;
    logic [95:0] cfg_regs;
    logic        trig_out;
    logic        busy;
    logic        ack_toggle;
    logic [15:0] cmd_count;
`ifdef PIO_SEQ_ERR_EN
    logic [7:0]  err_count;
    logic [0:0]  err_flag;
`endif

    int checks = 0;
    int errors = 0;
    int pulses;

    pio_cmd_sequencer #(.NUM_REGS(4), .STABLE_CYCLES(2)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .pio_data    (pio_data),
        .cfg_regs    (cfg_regs),
        .trig_out    (trig_out),
        .busy        (busy),
        .ack_toggle  (ack_toggle),
        .cmd_count   (cmd_count)
`ifdef PIO_SEQ_ERR_EN
        ,
        .err_count   (err_count),
        .err_flag    (err_flag)
`endif
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Present a word and step to the cycle after EXEC (STABLE_CYCLES+1 edges).
    task automatic apply_cmd(input logic [31:0] w);
        pio_data = w;
        repeat (3) tick();
    endtask

    function automatic logic [23:0] reg_at(input int i);
        return cfg_regs[i*24 +: 24];
    endfunction

    initial begin
        reset_reset = 1'b1;
        pio_data    = 32'h0;
        repeat (3) tick();
        reset_reset = 1'b0;

        // 1: reset state, matching toggle accepts nothing
        chk("rst_cfg",  32'(cfg_regs != 96'd0), 32'd0);
        chk("rst_trig", 32'(trig_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack",  32'(ack_toggle), 32'd0);
        chk("rst_cnt",  32'(cmd_count), 32'd0);
        repeat (4) tick();
        chk("idle_cnt", 32'(cmd_count), 32'd0);

        // 2: WRITE reg0=5, ack flips exactly STABLE_CYCLES+1 clocks later
        pio_data = 32'h9000_0005;
        tick(); tick();
        chk("wr_ack_early", 32'(ack_toggle), 32'd0);
        tick();
        chk("wr_ack",  32'(ack_toggle), 32'd1);
        chk("wr_cnt",  32'(cmd_count), 32'd1);
        chk("wr_reg0", 32'(reg_at(0)), 32'd5);

        // 3: START 3 with period 5: pulses at k=0,5,10, busy falls with the 3rd
        apply_cmd(32'h2000_0003);
        chk("st3_cnt", 32'(cmd_count), 32'd2);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("st3_trig_k%0d", k), 32'(trig_out), 32'((k == 0) || (k == 5) || (k == 10)));
            chk($sformatf("st3_busy_k%0d", k), 32'(busy), 32'(k < 10));
            tick();
        end

        // 4: START 100, STOP lands on the cycle a pulse is due; STOP wins
        apply_cmd(32'hA000_0064);
        chk("st100_trig", 32'(trig_out), 32'd1);
        chk("st100_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("st100_trig_k%0d", k), 32'(trig_out), 32'(k == 5));
        end
        apply_cmd(32'h3000_0000);
        chk("stop_trig", 32'(trig_out), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_cnt",  32'(cmd_count), 32'd4);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (trig_out) pulses++;
        end
        chk("stop_pulses", 32'(pulses), 32'd0);

        // START 0: acknowledged, no pulse, busy stays low
        pio_data = 32'hA000_0000;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (trig_out || busy) pulses++;
        end
        chk("st0_activity", 32'(pulses), 32'd0);
        chk("st0_cnt", 32'(cmd_count), 32'd5);
        chk("st0_ack", 32'(ack_toggle), 32'd1);

        // 5: one-cycle toggle glitch is rejected
        pio_data = 32'h1000_0000;
        tick();
        pio_data = 32'hA000_0000;
        repeat (5) tick();
        chk("glitch_cnt",  32'(cmd_count), 32'd5);
        chk("glitch_ack",  32'(ack_toggle), 32'd1);
        chk("glitch_reg0", 32'(reg_at(0)), 32'd5);

        // Out-of-range WRITE ignored, in-range WRITE reg3, CLEAR, illegal opcode
        apply_cmd(32'h1F00_1234);
        chk("wr15_cnt",  32'(cmd_count), 32'd6);
        chk("wr15_cfg",  32'(cfg_regs == {72'd0, 24'd5}), 32'd1);
`ifdef PIO_SEQ_ERR_EN
        chk("wr15_errc", 32'(err_count), 32'd1);
        chk("wr15_errf", 32'(err_flag), 32'd1);
`endif
        apply_cmd(32'h93AB_CDEF);
        chk("wr3_reg3", 32'(reg_at(3)), 32'hABCDEF);
        chk("wr3_reg0", 32'(reg_at(0)), 32'd5);
        apply_cmd(32'h4000_0000);
        chk("clr_cfg", 32'(cfg_regs != 96'd0), 32'd0);
        chk("clr_cnt", 32'(cmd_count), 32'd8);
`ifdef PIO_SEQ_ERR_EN
        chk("clr_errf", 32'(err_flag), 32'd0);
        chk("clr_errc", 32'(err_count), 32'd1);
`endif
        apply_cmd(32'hF000_0000);
        chk("op7_cnt", 32'(cmd_count), 32'd9);
        chk("op7_ack", 32'(ack_toggle), 32'd1);
        chk("op7_cfg", 32'(cfg_regs != 96'd0), 32'd0);
`ifdef PIO_SEQ_ERR_EN
        chk("op7_errc", 32'(err_count), 32'd2);
        chk("op7_errf", 32'(err_flag), 32'd1);
`endif

        // reg0=0 behaves as period 1: START 2 gives back-to-back pulses
        apply_cmd(32'h2000_0002);
        chk("p0_trig_k0", 32'(trig_out), 32'd1);
        chk("p0_busy_k0", 32'(busy), 32'd1);
        tick();
        chk("p0_trig_k1", 32'(trig_out), 32'd1);
        chk("p0_busy_k1", 32'(busy), 32'd0);
        tick();
        chk("p0_trig_k2", 32'(trig_out), 32'd0);

        // Reset in the middle of a burst
        apply_cmd(32'h9000_0004);
        apply_cmd(32'h2000_0032);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        tick(); tick();
        reset_reset = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt",  32'(cmd_count), 32'd0);
        chk("mid_rst_ack",  32'(ack_toggle), 32'd0);
        chk("mid_rst_cfg",  32'(cfg_regs != 96'd0), 32'd0);
        reset_reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (trig_out) pulses++;
        end
        chk("post_rst_pulses", 32'(pulses), 32'd0);
        chk("post_rst_cnt", 32'(cmd_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
